// File: rtl/axi_read_burst_scheduler.sv
// AXI4 read-address sequencer for the DDR FIFO read path: fixed-length INCR bursts over a circular region.
// Optional statistics counters (stat_bursts, stat_stall) are built when RD_SCHED_STATS_EN is defined.
module axi_read_burst_scheduler #(
   parameter int                unsigned ADDR_W          = 32,
   parameter int                unsigned DATA_W          = 64,
   parameter int                unsigned BURST_LEN       = 16,
   parameter logic [ADDR_W-1:0]          BASE_ADDR       = '0,
   parameter int                unsigned REGION_BYTES    = 1048576,
   parameter int                unsigned MAX_OUTSTANDING = 4
) (
   input  logic              M_AXI_ACLK,
   input  logic              M_AXI_ARESETN,
   input  logic              rd_en,
   input  logic [31:0]       ddr_avail_beats,
   input  logic [15:0]       fifo_free,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic [7:0]        M_AXI_ARLEN,
   output logic [2:0]        M_AXI_ARSIZE,
   output logic [1:0]        M_AXI_ARBURST,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic              M_AXI_RVALID,
   input  logic              M_AXI_RREADY,
   input  logic              M_AXI_RLAST,
   output logic              rd_commit,
   output logic [2:0]        outstanding,
   output logic              rd_busy
`ifdef RD_SCHED_STATS_EN
   ,
   output logic [31:0]       stat_bursts,
   output logic [31:0]       stat_stall
`endif
);

   localparam int unsigned       BURST_BYTES = BURST_LEN * (DATA_W / 8);
   localparam logic [ADDR_W-1:0] STEP_A      = ADDR_W'(BURST_BYTES);
   localparam logic [ADDR_W-1:0] END_A       = BASE_ADDR + ADDR_W'(REGION_BYTES);
   localparam logic [31:0]       BL32        = 32'(BURST_LEN);
   localparam logic [31:0]       MAX_OUT32   = 32'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_ADDR
   } state_t;

   state_t            state_reg;
   logic              arvalid_reg;
   logic [ADDR_W-1:0] araddr_reg;
   logic              rd_en_reg;
   logic [31:0]       ddr_avail_reg;
   logic [15:0]       fifo_free_reg;
   logic [31:0]       res_reg;
   logic [31:0]       res_next;
   logic [2:0]        outstanding_reg;
   logic [2:0]        outstanding_next;
   logic              rd_commit_reg;
   logic [ADDR_W-1:0] addr_next;
   logic              ar_hs;
   logic              r_hs;
   logic              last_hs;
   logic              fifo_ok;
   logic              ddr_ok;
   logic              slot_ok;
   logic              issue_ok;

   assign ar_hs   = arvalid_reg & M_AXI_ARREADY;
   assign r_hs    = M_AXI_RVALID & M_AXI_RREADY;
   assign last_hs = r_hs & M_AXI_RLAST;

   // FIFO must absorb every reserved beat plus the new burst
   assign fifo_ok  = {16'd0, fifo_free_reg} >= (res_reg + BL32);
   assign ddr_ok   = ddr_avail_reg >= ((32'(outstanding_reg) + 32'd1) * BL32);
   assign slot_ok  = 32'(outstanding_reg) < MAX_OUT32;
   assign issue_ok = rd_en_reg & slot_ok & fifo_ok & ddr_ok;

   assign addr_next = ((araddr_reg + STEP_A) == END_A) ? BASE_ADDR : (araddr_reg + STEP_A);

   always_comb begin
      res_next = res_reg;
      if (ar_hs && r_hs) begin
         res_next = res_reg + BL32 - 32'd1;
      end else if (ar_hs) begin
         res_next = res_reg + BL32;
      end else if (r_hs && (res_reg != 32'd0)) begin
         res_next = res_reg - 32'd1;
      end
   end

   // An RLAST with nothing outstanding is a protocol error; hold at zero
   always_comb begin
      outstanding_next = outstanding_reg;
      if (ar_hs && !last_hs) begin
         outstanding_next = outstanding_reg + 3'd1;
      end else if (!ar_hs && last_hs && (outstanding_reg != 3'd0)) begin
         outstanding_next = outstanding_reg - 3'd1;
      end
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         rd_en_reg       <= 1'b0;
         ddr_avail_reg   <= '0;
         fifo_free_reg   <= '0;
         res_reg         <= '0;
         outstanding_reg <= '0;
         rd_commit_reg   <= 1'b0;
      end else begin
         rd_en_reg       <= rd_en;
         ddr_avail_reg   <= ddr_avail_beats;
         fifo_free_reg   <= fifo_free;
         res_reg         <= res_next;
         outstanding_reg <= outstanding_next;
         rd_commit_reg   <= last_hs;
      end
   end

   // ARVALID and ARADDR stay frozen in ADDR until accepted, whatever rd_en does
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_reg   <= ST_IDLE;
         arvalid_reg <= 1'b0;
         araddr_reg  <= BASE_ADDR;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (issue_ok) begin
                  arvalid_reg <= 1'b1;
                  state_reg   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (ar_hs) begin
                  arvalid_reg <= 1'b0;
                  araddr_reg  <= addr_next;
                  state_reg   <= ST_IDLE;
               end
            end
            default: begin
               arvalid_reg <= 1'b0;
               state_reg   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef RD_SCHED_STATS_EN
   logic [31:0] stat_bursts_reg;
   logic [31:0] stat_stall_reg;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         stat_bursts_reg <= '0;
         stat_stall_reg  <= '0;
      end else begin
         if (ar_hs) begin
            stat_bursts_reg <= stat_bursts_reg + 32'd1;
         end
         if ((state_reg == ST_IDLE) && rd_en_reg && !issue_ok && (stat_stall_reg != '1)) begin
            stat_stall_reg <= stat_stall_reg + 32'd1;
         end
      end
   end

   assign stat_bursts = stat_bursts_reg;
   assign stat_stall  = stat_stall_reg;
`endif

   assign M_AXI_ARADDR  = araddr_reg;
   assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_ARSIZE  = 3'($clog2(DATA_W / 8));
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARVALID = arvalid_reg;
   assign rd_commit     = rd_commit_reg;
   assign outstanding   = outstanding_reg;
   assign rd_busy       = arvalid_reg | (outstanding_reg != 3'd0);

endmodule

// File: tb/tb_axi_read_burst_scheduler.sv
// Directed bench for axi_read_burst_scheduler: small region (8 bursts) so the address wrap is reachable.
module tb_axi_read_burst_scheduler;

   localparam logic [31:0] BASE   = 32'h0001_0000;
   localparam int          REGION = 1024;
   localparam logic [31:0] STEP   = 32'h80;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] ddr_avail_beats = 32'd0;
   logic [15:0] fifo_free = 16'd0;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready = 1'b0;
   logic        rlast = 1'b0;
   logic        rd_commit;
   logic [2:0]  outstanding;
   logic        rd_busy;
`ifdef RD_SCHED_STATS_EN
   logic [31:0] stat_bursts;
   logic [31:0] stat_stall;
`endif

   int          checks = 0;
   int          failures = 0;
   int          ar_cnt = 0;
   int          commit_cnt = 0;
   logic [31:0] ar_q[$];
   logic [31:0] exp_addr = BASE;

   always #5 clk = ~clk;

   axi_read_burst_scheduler #(
      .ADDR_W(32), .DATA_W(64), .BURST_LEN(16), .BASE_ADDR(BASE),
      .REGION_BYTES(REGION), .MAX_OUTSTANDING(4)
   ) dut (
      .M_AXI_ACLK(clk),
      .M_AXI_ARESETN(rst_n),
      .rd_en(rd_en),
      .ddr_avail_beats(ddr_avail_beats),
      .fifo_free(fifo_free),
      .M_AXI_ARADDR(araddr),
      .M_AXI_ARLEN(arlen),
      .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst),
      .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RVALID(rvalid),
      .M_AXI_RREADY(rready),
      .M_AXI_RLAST(rlast),
      .rd_commit(rd_commit),
      .outstanding(outstanding),
      .rd_busy(rd_busy)
`ifdef RD_SCHED_STATS_EN
      ,
      .stat_bursts(stat_bursts),
      .stat_stall(stat_stall)
`endif
   );

   always @(posedge clk) begin
      if (arvalid && arready) begin
         ar_cnt++;
         ar_q.push_back(araddr);
      end
      if (rd_commit) commit_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic expect_ar(input string tag);
      logic [31:0] a;
      if (ar_q.size() == 0) begin
         chk({tag, "_present"}, 64'd0, 64'd1);
      end else begin
         a = ar_q.pop_front();
         chk(tag, 64'(a), 64'(exp_addr));
      end
      exp_addr = exp_addr + STEP;
      if (exp_addr == BASE + 32'(REGION)) exp_addr = BASE;
   endtask

   task automatic wait_arvalid(input string tag);
      int n = 0;
      while (!arvalid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_arvalid"}, 64'(arvalid), 64'd1);
   endtask

   task automatic wait_ar_cnt(input int target, input string tag);
      int n = 0;
      while (ar_cnt < target && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(ar_cnt), 64'(target));
   endtask

   task automatic drive_beats(input int n, input bit last_at_end);
      for (int i = 0; i < n; i++) begin
         rvalid = 1'b1;
         rready = 1'b1;
         rlast  = last_at_end && (i == n - 1);
         @(negedge clk);
      end
      rvalid = 1'b0;
      rready = 1'b0;
      rlast  = 1'b0;
   endtask

   // Issue exactly one AR: hold ARREADY low until ARVALID, drop rd_en, then accept
   task automatic issue_one(input string tag);
      arready = 1'b0;
      rd_en   = 1'b1;
      wait_arvalid(tag);
      rd_en = 1'b0;
      chk({tag, "_addr"}, 64'(araddr), 64'(exp_addr));
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      expect_ar({tag, "_ar"});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_cnt;
      logic [31:0] held;

      // Test 1: reset values, then four ARs and a stall at MAX_OUTSTANDING
      ddr_avail_beats = 32'd64;
      fifo_free       = 16'd512;
      arready         = 1'b1;
      rd_en           = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_araddr", 64'(araddr), 64'(BASE));
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_commit", 64'(rd_commit), 64'd0);
      chk("arlen", 64'(arlen), 64'd15);
      chk("arsize", 64'(arsize), 64'd3);
      chk("arburst", 64'(arburst), 64'd1);
`ifdef RD_SCHED_STATS_EN
      chk("rst_stat_bursts", 64'(stat_bursts), 64'd0);
`endif
      rst_n = 1'b1;
      wait_ar_cnt(4, "t1_ar_count");
      repeat (10) @(negedge clk);
      chk("t1_stall_count", 64'(ar_cnt), 64'd4);
      chk("t1_outstanding", 64'(outstanding), 64'd4);
      chk("t1_busy", 64'(rd_busy), 64'd1);
      for (int i = 0; i < 4; i++) expect_ar($sformatf("t1_ar%0d", i));
`ifdef RD_SCHED_STATS_EN
      chk("t1_stat_bursts", 64'(stat_bursts), 64'd4);
      chk("t1_stat_stall_nz", 64'(stat_stall != 32'd0), 64'd1);
`endif
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_beats(16, 1'b1);
      @(negedge clk);
      chk("t1_commits", 64'(commit_cnt), 64'd4);
      chk("t1_drained", 64'(outstanding), 64'd0);
      chk("t1_idle_busy", 64'(rd_busy), 64'd0);

      // Test 2: ARREADY low 10 cycles, rd_en dropped mid-wait
      arready = 1'b0;
      rd_en   = 1'b1;
      wait_arvalid("t2");
      held = araddr;
      chk("t2_addr", 64'(held), 64'(exp_addr));
      base_cnt = ar_cnt;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) rd_en = 1'b0;
         @(negedge clk);
         chk($sformatf("t2_hold_valid_c%0d", c), 64'(arvalid), 64'd1);
         chk($sformatf("t2_hold_addr_c%0d", c), 64'(araddr), 64'(held));
      end
      arready = 1'b1;
      repeat (6) @(negedge clk);
      chk("t2_one_ar", 64'(ar_cnt - base_cnt), 64'd1);
      expect_ar("t2_ar");
      drive_beats(16, 1'b1);
      @(negedge clk);
      chk("t2_drained", 64'(outstanding), 64'd0);

      // Test 3: fifo_free=20 allows one burst; the next needs res <= 4
      fifo_free = 16'd20;
      rd_en     = 1'b1;
      base_cnt  = ar_cnt;
      wait_ar_cnt(base_cnt + 1, "t3_first");
      drive_beats(11, 1'b0);
      rvalid = 1'b1;
      repeat (3) @(negedge clk);
      rvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_blocked", 64'(ar_cnt), 64'(base_cnt + 1));
      drive_beats(1, 1'b0);
      wait_ar_cnt(base_cnt + 2, "t3_second");
      rd_en = 1'b0;
      expect_ar("t3_ar0");
      expect_ar("t3_ar1");
      drive_beats(4, 1'b1);
      drive_beats(16, 1'b1);
      @(negedge clk);
      chk("t3_drained", 64'(outstanding), 64'd0);
      fifo_free = 16'd512;

      // Test 4: last burst of the region wraps the address
      chk("t4_pre_addr", 64'(araddr), 64'(BASE + 32'(REGION) - STEP));
      issue_one("t4");
      chk("t4_wrap", 64'(araddr), 64'(BASE));
      chk("t4_out", 64'(outstanding), 64'd1);

      // Test 5: AR and RLAST accepted in the same cycle
      drive_beats(15, 1'b0);
      rd_en = 1'b1;
      wait_arvalid("t5");
      rd_en = 1'b0;
      chk("t5_addr", 64'(araddr), 64'(exp_addr));
      arready = 1'b1;
      rvalid  = 1'b1;
      rready  = 1'b1;
      rlast   = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      rvalid  = 1'b0;
      rready  = 1'b0;
      rlast   = 1'b0;
      chk("t5_out_same", 64'(outstanding), 64'd1);
      chk("t5_commit", 64'(rd_commit), 64'd1);
      expect_ar("t5_ar");
      @(negedge clk);
      chk("t5_commit_end", 64'(rd_commit), 64'd0);

      // Back-to-back RLASTs, then an RLAST with nothing outstanding
      issue_one("b2b");
      chk("b2b_out2", 64'(outstanding), 64'd2);
      drive_beats(15, 1'b0);
      rvalid = 1'b1;
      rready = 1'b1;
      rlast  = 1'b1;
      @(negedge clk);
      chk("b2b_commit1", 64'(rd_commit), 64'd1);
      @(negedge clk);
      rvalid = 1'b0;
      rready = 1'b0;
      rlast  = 1'b0;
      chk("b2b_commit2", 64'(rd_commit), 64'd1);
      chk("b2b_out0", 64'(outstanding), 64'd0);
      @(negedge clk);
      chk("b2b_commit_end", 64'(rd_commit), 64'd0);
      drive_beats(1, 1'b1);
      chk("sat_out", 64'(outstanding), 64'd0);
      chk("sat_busy", 64'(rd_busy), 64'd0);

      // Test 6: asynchronous reset with ARVALID high and two outstanding
      issue_one("t6a");
      issue_one("t6b");
      rd_en = 1'b1;
      wait_arvalid("t6");
      chk("t6_out2", 64'(outstanding), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_arvalid", 64'(arvalid), 64'd0);
      chk("t6_araddr", 64'(araddr), 64'(BASE));
      chk("t6_out", 64'(outstanding), 64'd0);
      chk("t6_commit", 64'(rd_commit), 64'd0);
      chk("t6_busy", 64'(rd_busy), 64'd0);
      // With res cleared, fifo_free=16 is just enough for one burst
      @(negedge clk);
      ar_q.delete();
      exp_addr  = BASE;
      fifo_free = 16'd16;
      arready   = 1'b1;
      base_cnt  = ar_cnt;
      rst_n     = 1'b1;
      wait_ar_cnt(base_cnt + 1, "t6_post_ar");
      rd_en = 1'b0;
      expect_ar("t6_post_addr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
